imem_loader: RTL and testbench

Boot-time writer for the 4096 x 32 instruction memory. It receives a framed byte stream from an upstream byte source, assembles little-endian 32-bit words, and writes them to consecutive instruction-memory addresses starting at 0. While a frame is in progress it holds the processor in reset, and it releases the processor only after the frame checksum verifies. It sits between the board-level byte receiver and the write port of the instruction memory, alongside the processor's read-only fetch path.

---
 rtl/imem_loader.sv | 218 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Receives a framed byte stream (0xA5, LEN_LO, LEN_HI, 4*N data bytes LSB first, CSUM),
// assembles 32-bit little-endian words and writes them to consecutive addresses from 0.
// Holds the processor in reset while a frame is in progress or after an error.
//
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   byte_in       - incoming byte, qualified by byte_valid
//   byte_valid    - byte_in valid this cycle
//   byte_ready    - loader can accept a byte (low only in the write cycle)
//   imem_wEn      - one-cycle write strobe to instruction memory
//   imem_addr     - write address (word index)
//   imem_dataIn   - write data (assembled word)
//   cpu_reset     - processor reset request
//   busy          - frame in progress
//   done          - one-cycle pulse on a frame completing with good checksum
//   err           - sticky error, cleared by the next header or by reset
//
// Optional feature: define IMEM_LOADER_TIMEOUT_EN to abort a frame whose inter-byte gap
// reaches TIMEOUT_CYCLES.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_wEn,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_dataIn,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [15:0] MaxWords = 16'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StWrite, StCsum} state_e;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [7:0]            csum_q, csum_d;
  logic                  ready_q, ready_d;
  logic                  wen_q, wen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cpu_rst_q, cpu_rst_d;

  logic        accept;
  logic        last_word;
  logic        timeout;
  logic [15:0] len_full;

  assign accept    = byte_valid & ready_q;
  assign len_full  = {byte_in, len_lo_q};
  assign last_word = ({1'b0, addr_q} + (ADDR_WIDTH + 1)'(1)) == len_q;

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  assign timeout = (state_q != StIdle) && (tcnt_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == StIdle || accept) begin
      tcnt_d = '0;
    end else if (!timeout) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    addr_d   = addr_q;
    data_d   = data_q;
    bcnt_d   = bcnt_q;
    csum_d   = csum_q;
    err_d    = err_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && byte_in == 8'hA5) begin
          state_d = StLenLo;
          err_d   = 1'b0;
          csum_d  = '0;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_lo_d = byte_in;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d  = len_full[ADDR_WIDTH:0];
          addr_d = '0;
          bcnt_d = '0;
          if (len_full > MaxWords) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (len_full == '0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          data_d[{bcnt_q, 3'b000} +: 8] = byte_in;
          csum_d = csum_q ^ byte_in;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        // The last word keeps its address so a full 4096-word image never wraps to 0.
        if (last_word) begin
          state_d = StCsum;
        end else begin
          state_d = StData;
          addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = StIdle;
          if (byte_in == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end

    // Outputs are registered from the next state so they line up with the state register.
    busy_d    = (state_d != StIdle);
    ready_d   = (state_d != StWrite);
    wen_d     = (state_d == StWrite);
    cpu_rst_d = busy_d | err_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      len_lo_q  <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      bcnt_q    <= '0;
      csum_q    <= '0;
      ready_q   <= 1'b1;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bcnt_q    <= bcnt_d;
      csum_q    <= csum_d;
      ready_q   <= ready_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  assign byte_ready  = ready_q;
  assign imem_wEn    = wen_q;
  assign imem_addr   = addr_q;
  assign imem_dataIn = data_q;
  assign cpu_reset   = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_wEn;
  logic [11:0] imem_addr;
  logic [31:0] imem_dataIn;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [11:0] wa[$];
  logic [31:0] wd[$];
  int          done_cnt = 0;
  int          rl_cnt = 0;

  imem_loader #(
    .ADDR_WIDTH    (12),
    .DATA_WIDTH    (32),
`ifdef IMEM_LOADER_TIMEOUT_EN
    .TIMEOUT_CYCLES(16)
`else
    .TIMEOUT_CYCLES(1000000)
`endif
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_wEn   (imem_wEn),
    .imem_addr  (imem_addr),
    .imem_dataIn(imem_dataIn),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (imem_wEn) begin
        wa.push_back(imem_addr);
        wd.push_back(imem_dataIn);
      end
      if (done) done_cnt++;
      if (!byte_ready) rl_cnt++;
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
    rl_cnt   = 0;
  endtask

  // Presents a byte and returns 1ns after the edge that accepted it; byte_valid stays high.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 8) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte: byte_ready stuck at %0b, required 1", byte_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input bq_t f);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({byte_ready, imem_wEn, busy, done, err, cpu_reset} !== 6'b100001) begin
      errors++;
      $display("FAIL reset_flags: got rdy/wen/busy/done/err/cpurst=%b, required 100001",
               {byte_ready, imem_wEn, busy, done, err, cpu_reset});
    end
    checks++;
    if (imem_addr !== 12'd0 || imem_dataIn !== 32'd0) begin
      errors++;
      $display("FAIL reset_addr_data: got addr=%h data=%h, required 000 00000000",
               imem_addr, imem_dataIn);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cpu_reset=%b, required 0", cpu_reset);
    end
  endtask

  task automatic test_good_frame();
    bq_t f;
    clear_log();
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_frame(f);
    // Fourth byte of word 0 just accepted: the write must be on now.
    checks++;
    if (imem_wEn !== 1'b1 || byte_ready !== 1'b0 || imem_addr !== 12'd0 ||
        imem_dataIn !== 32'h00000013) begin
      errors++;
      $display("FAIL write_latency: wen=%b rdy=%b addr=%h data=%h, required 1 0 000 00000013",
               imem_wEn, byte_ready, imem_addr, imem_dataIn);
    end
    checks++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL in_frame: busy=%b cpu_reset=%b, required 1 1", busy, cpu_reset);
    end
    // XOR of 13 00 00 00 93 00 10 00 is 0x90.
    f = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(f);
    checks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL good_end: done=%b cpu_reset=%b busy=%b err=%b, required 1 0 0 0",
               done, cpu_reset, busy, err);
    end
    idle(3);
    checks++;
    if (wa.size() != 2 || done_cnt != 1) begin
      errors++;
      $display("FAIL good_counts: writes=%0d dones=%0d, required 2 1", wa.size(), done_cnt);
    end else begin
      checks++;
      if (wa[0] !== 12'd0 || wd[0] !== 32'h00000013 || wa[1] !== 12'd1 ||
          wd[1] !== 32'h00100093) begin
        errors++;
        $display("FAIL good_words: %h:%h %h:%h, required 000:00000013 001:00100093",
                 wa[0], wd[0], wa[1], wd[1]);
      end
    end
  endtask

  task automatic test_bad_csum();
    bq_t f;
    clear_log();
    f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h19};
    send_frame(f);
    idle(2);
    checks++;
    if (err !== 1'b1 || cpu_reset !== 1'b1 || busy !== 1'b0 || done_cnt != 0 ||
        wa.size() != 2) begin
      errors++;
      $display("FAIL bad_csum: err=%b cpu_reset=%b busy=%b dones=%0d writes=%0d, required 1 1 0 0 2",
               err, cpu_reset, busy, done_cnt, wa.size());
    end
    clear_log();
    send_byte(8'hA5);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear_on_header: err=%b busy=%b, required 0 1", err, busy);
    end
    f = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame(f);
    idle(2);
    checks++;
    if (err !== 1'b0 || cpu_reset !== 1'b0 || done_cnt != 1 || wa.size() != 1) begin
      errors++;
      $display("FAIL recover: err=%b cpu_reset=%b dones=%0d writes=%0d, required 0 0 1 1",
               err, cpu_reset, done_cnt, wa.size());
    end else begin
      checks++;
      if (wa[0] !== 12'd0 || wd[0] !== 32'h04030201) begin
        errors++;
        $display("FAIL recover_word: %h:%h, required 000:04030201", wa[0], wd[0]);
      end
    end
  endtask

  task automatic test_zero_len();
    bq_t f;
    clear_log();
    f = '{8'h00, 8'hFF};
    send_frame(f);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL noise_ignored: busy=%b, required 0", busy);
    end
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(f);
    idle(2);
    checks++;
    if (done_cnt != 1 || wa.size() != 0 || err !== 1'b0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: dones=%0d writes=%0d err=%b cpu_reset=%b, required 1 0 0 0",
               done_cnt, wa.size(), err, cpu_reset);
    end
  endtask

  task automatic test_len_err();
    bq_t f;
    clear_log();
    f = '{8'hA5, 8'h01, 8'h10};
    send_frame(f);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL len_err: err=%b busy=%b cpu_reset=%b, required 1 0 1", err, busy, cpu_reset);
    end
    // A following zero-length frame only completes if the FSM went back to idle.
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(f);
    idle(2);
    checks++;
    if (wa.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL len_err_idle: writes=%0d dones=%0d, required 0 1", wa.size(), done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bq_t         f;
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h11223344;
    exp_w[1] = 32'hA5A5A5A5;
    exp_w[2] = 32'hDEADBEEF;
    clear_log();
    // CSUM: 44^33^22^11 = 44, A5 x4 = 00, EF^BE^AD^DE = 22 -> 66.
    f = '{8'hA5, 8'h03, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
    send_frame(f);
    idle(2);
    checks++;
    if (rl_cnt != 3) begin
      errors++;
      $display("FAIL ready_low_cycles: got %0d, required 3", rl_cnt);
    end
    checks++;
    if (wa.size() != 3 || done_cnt != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counts: writes=%0d dones=%0d err=%b, required 3 1 0",
               wa.size(), done_cnt, err);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wa[i] !== 12'(i) || wd[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL b2b_word%0d: %h:%h, required %h:%h", i, wa[i], wd[i], 12'(i), exp_w[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    bq_t f;
    clear_log();
    f = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_frame(f);
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || cpu_reset !== 1'b1 || imem_wEn !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: busy=%b cpu_reset=%b wen=%b, required 0 1 0",
               busy, cpu_reset, imem_wEn);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(2);
    // CSUM: 78^56^34^12 = 08.
    f = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_frame(f);
    idle(2);
    checks++;
    if (wa.size() != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL after_reset_counts: writes=%0d dones=%0d, required 1 1", wa.size(), done_cnt);
    end else begin
      checks++;
      if (wa[0] !== 12'd0 || wd[0] !== 32'h12345678) begin
        errors++;
        $display("FAIL after_reset_word: %h:%h, required 000:12345678", wa[0], wd[0]);
      end
    end
  endtask

`ifdef IMEM_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    bq_t f;
    clear_log();
    f = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_frame(f);
    idle(20);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_reset !== 1'b1 || wa.size() != 0) begin
      errors++;
      $display("FAIL timeout: err=%b busy=%b cpu_reset=%b writes=%0d, required 1 0 1 0",
               err, busy, cpu_reset, wa.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_zero_len();
    test_len_err();
    test_back_to_back();
    test_reset_midframe();
`ifdef IMEM_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
